// File: rtl/stack_unit_pkg.sv
// ----------------------------------------------------------------------------
// stack_unit_pkg
// Shared definitions for the stack unit and the CPUs that drive it:
//   - 4-bit opcode encodings (OP_*)
//   - minimum stack depth each opcode needs before it can execute
//   - min_depth() lookup helper (codes above OP_REPL need no operands)
// ----------------------------------------------------------------------------
package stack_unit_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_NOP  = 4'd0;
    localparam logic [OP_W-1:0] OP_PUSH = 4'd1;
    localparam logic [OP_W-1:0] OP_DROP = 4'd2;
    localparam logic [OP_W-1:0] OP_DUP  = 4'd3;
    localparam logic [OP_W-1:0] OP_SWAP = 4'd4;
    localparam logic [OP_W-1:0] OP_OVER = 4'd5;
    localparam logic [OP_W-1:0] OP_ROT  = 4'd6;
    localparam logic [OP_W-1:0] OP_BIN  = 4'd7;
    localparam logic [OP_W-1:0] OP_REPL = 4'd8;

    localparam int NUM_OPS = 9;

    // Entries (TOS, NOS, RAM) that must be present, indexed by opcode.
    localparam logic [1:0] MIN_DEPTH_TBL [NUM_OPS] = '{
        2'd0,   // NOP
        2'd0,   // PUSH
        2'd1,   // DROP
        2'd1,   // DUP
        2'd2,   // SWAP
        2'd2,   // OVER
        2'd3,   // ROT
        2'd2,   // BIN
        2'd1    // REPL
    };

    function automatic logic [1:0] min_depth(input logic [OP_W-1:0] op);
        logic [1:0] result;
        result = 2'd0;
        if (op <= OP_REPL) begin
            result = MIN_DEPTH_TBL[op];
        end
        return result;
    endfunction

endpackage

// File: rtl/stack_unit_ram.sv
// ----------------------------------------------------------------------------
// stack_unit_ram
// Spill storage for the entries below NOS. DEPTH x W words, synchronous
// write, synchronous (registered) read. When the read and write addresses
// match in the same cycle the read returns the data being written, so the
// stack can re-read a just-spilled word on the very next cycle.
// Ports:
//   clk           clock
//   we/waddr/wdata write port
//   raddr         read address, sampled on the rising edge
//   rdata         registered read data
// ----------------------------------------------------------------------------
module stack_unit_ram #(
    parameter  int W     = 32,
    parameter  int DEPTH = 256,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (we && (waddr == raddr)) begin
            rdata_reg <= wdata;
        end else begin
            rdata_reg <= mem[raddr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/stack_unit.sv
// ----------------------------------------------------------------------------
// stack_unit
// Hardware data stack with registered TOS/NOS and a RAM spill area of DEPTH
// words underneath. One command per cycle, no stall.
// Build option:
//   STACK_UNIT_GUARD_EN  - when defined, commands that would overflow or
//                          underflow are suppressed and flag ovf/unf.
//                          When undefined, every command executes, the
//                          pointers wrap and ovf/unf stay 0.
// Ports:
//   clk        clock (rising edge)
//   rst        asynchronous active-low reset
//   cmd_valid  command present this cycle
//   cmd_op     opcode (see stack_unit_pkg)
//   din        operand for PUSH, BIN, REPL
//   clr_err    clears sticky ovf/unf/ill (a same-cycle set wins)
//   tos, nos   registered top / next-on-stack
//   depth      valid entries including TOS and NOS
//   full/empty depth == DEPTH+2 / depth == 0
//   ovf/unf/ill sticky overflow, underflow, illegal-opcode flags
// ----------------------------------------------------------------------------
module stack_unit
    import stack_unit_pkg::*;
#(
    parameter  int W     = 32,
    parameter  int DEPTH = 256,
    localparam int DW    = $clog2(DEPTH + 3)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    input  logic [OP_W-1:0] cmd_op,
    input  logic [W-1:0]    din,
    input  logic            clr_err,
    output logic [W-1:0]    tos,
    output logic [W-1:0]    nos,
    output logic [DW-1:0]   depth,
    output logic            full,
    output logic            empty,
    output logic            ovf,
    output logic            unf,
    output logic            ill
);

    localparam int            AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH + 2);

    logic [W-1:0]  tos_reg, tos_next;
    logic [W-1:0]  nos_reg, nos_next;
    logic [AW-1:0] sp_reg, sp_next;
    logic [DW-1:0] depth_reg, depth_next;
    logic          ovf_reg, unf_reg, ill_reg;
    logic          armed_reg;

    logic          accept;
    logic          known_op;
    logic          blocked;
    logic          exec;
    logic          ovf_set, unf_set, ill_set;

    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [W-1:0]  ram_wdata;
    logic [AW-1:0] ram_raddr;
    logic [W-1:0]  ram_rdata;

    // armed_reg is low for the first edge after reset release, so a
    // command presented in that cycle is ignored.
    assign accept   = cmd_valid & armed_reg;
    assign known_op = (cmd_op <= OP_REPL);

`ifdef STACK_UNIT_GUARD_EN
    logic too_shallow;
    logic overflow;

    assign too_shallow = (depth_reg < DW'(min_depth(cmd_op)));
    assign overflow    = ((cmd_op == OP_PUSH) || (cmd_op == OP_DUP) || (cmd_op == OP_OVER))
                         && (depth_reg == DEPTH_MAX);
    assign blocked     = too_shallow | overflow;
    assign ovf_set     = accept & known_op & overflow;
    assign unf_set     = accept & known_op & too_shallow;
`else
    assign blocked     = 1'b0;
    assign ovf_set     = 1'b0;
    assign unf_set     = 1'b0;
`endif

    assign ill_set = accept & ~known_op;
    assign exec    = accept & known_op & ~blocked;

    always_comb begin
        tos_next   = tos_reg;
        nos_next   = nos_reg;
        sp_next    = sp_reg;
        depth_next = depth_reg;
        ram_we     = 1'b0;
        ram_waddr  = sp_reg;
        ram_wdata  = nos_reg;

        if (exec) begin
            case (cmd_op)
                OP_PUSH, OP_DUP, OP_OVER: begin
                    if (cmd_op == OP_PUSH) begin
                        tos_next = din;
                    end else if (cmd_op == OP_DUP) begin
                        tos_next = tos_reg;
                    end else begin
                        tos_next = nos_reg;
                    end
                    nos_next   = tos_reg;
                    depth_next = depth_reg + DW'(1);
                    // Old NOS only needs a RAM slot once both registers hold data.
                    if (depth_reg >= DW'(2)) begin
                        ram_we  = 1'b1;
                        sp_next = sp_reg + AW'(1);
                    end
                end
                OP_DROP, OP_BIN: begin
                    tos_next   = (cmd_op == OP_BIN) ? din : nos_reg;
                    depth_next = depth_reg - DW'(1);
                    if (depth_reg > DW'(2)) begin
                        nos_next = ram_rdata;
                        sp_next  = sp_reg - AW'(1);
                    end else begin
                        nos_next = '0;
                    end
                end
                OP_SWAP: begin
                    tos_next = nos_reg;
                    nos_next = tos_reg;
                end
                OP_ROT: begin
                    // ( a b c -> b c a ): a comes up from RAM, b goes down.
                    tos_next  = ram_rdata;
                    nos_next  = tos_reg;
                    ram_we    = 1'b1;
                    ram_waddr = sp_reg - AW'(1);
                end
                OP_REPL: begin
                    tos_next = din;
                end
                default: begin
                end
            endcase

            if (depth_next == '0) begin
                tos_next = '0;
            end
            if (depth_next <= DW'(1)) begin
                nos_next = '0;
            end
        end
    end

    // Read-ahead: fetch the word that will sit just below NOS after this
    // edge, so a following pop or ROT finds it already in ram_rdata.
    assign ram_raddr = sp_next - AW'(1);

    stack_unit_ram #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tos_reg   <= '0;
            nos_reg   <= '0;
            sp_reg    <= '0;
            depth_reg <= '0;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
            ill_reg   <= 1'b0;
            armed_reg <= 1'b0;
        end else begin
            tos_reg   <= tos_next;
            nos_reg   <= nos_next;
            sp_reg    <= sp_next;
            depth_reg <= depth_next;
            ovf_reg   <= ovf_set | (ovf_reg & ~clr_err);
            unf_reg   <= unf_set | (unf_reg & ~clr_err);
            ill_reg   <= ill_set | (ill_reg & ~clr_err);
            armed_reg <= 1'b1;
        end
    end

    assign tos   = tos_reg;
    assign nos   = nos_reg;
    assign depth = depth_reg;
    assign full  = (depth_reg == DEPTH_MAX);
    assign empty = (depth_reg == '0);
    assign ovf   = ovf_reg;
    assign unf   = unf_reg;
    assign ill   = ill_reg;

endmodule

// File: tb/tb_stack_unit.sv
// ----------------------------------------------------------------------------
// tb_stack_unit
// Directed bench for stack_unit (W=32, DEPTH=4). Expected values are written
// by hand; where the guard option changes the outcome, both results are
// spelled out and selected by STACK_UNIT_GUARD_EN.
// ----------------------------------------------------------------------------
module tb_stack_unit;
    import stack_unit_pkg::*;

    localparam int W     = 32;
    localparam int DEPTH = 4;
    localparam int DW    = $clog2(DEPTH + 3);

`ifdef STACK_UNIT_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic            clk;
    logic            rst;
    logic            cmd_valid;
    logic [OP_W-1:0] cmd_op;
    logic [W-1:0]    din;
    logic            clr_err;
    logic [W-1:0]    tos;
    logic [W-1:0]    nos;
    logic [DW-1:0]   depth;
    logic            full;
    logic            empty;
    logic            ovf;
    logic            unf;
    logic            ill;

    int vectors   = 0;
    int miscompares = 0;

    stack_unit #(
        .W     (W),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .din       (din),
        .clr_err   (clr_err),
        .tos       (tos),
        .nos       (nos),
        .depth     (depth),
        .full      (full),
        .empty     (empty),
        .ovf       (ovf),
        .unf       (unf),
        .ill       (ill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // One command per call; inputs change just after an edge so calls
    // issued back to back land on consecutive clock cycles.
    task automatic cmd(input logic [OP_W-1:0] op, input logic [W-1:0] d, input logic clr);
        cmd_valid = 1'b1;
        cmd_op    = op;
        din       = d;
        clr_err   = clr;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        clr_err   = 1'b0;
        $display("cmd op=%0d din=%0d clr=%0d -> tos=%0d nos=%0d depth=%0d full=%0d empty=%0d ovf=%0d unf=%0d ill=%0d",
                 op, d, clr, tos, nos, depth, full, empty, ovf, unf, ill);
    endtask

    task automatic idle(input logic clr);
        cmd_valid = 1'b0;
        cmd_op    = OP_PUSH;
        din       = 32'd777;
        clr_err   = clr;
        @(posedge clk);
        #1;
        clr_err   = 1'b0;
        $display("idle clr=%0d -> tos=%0d nos=%0d depth=%0d ovf=%0d unf=%0d ill=%0d",
                 clr, tos, nos, depth, ovf, unf, ill);
    endtask

    // Asynchronous reset pulse placed between clock edges, then release
    // with a PUSH presented in the release cycle (it must be dropped).
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        $display("reset %s asserted -> tos=%0d nos=%0d depth=%0d", tag, tos, nos, depth);
        chk({tag, "_rst_tos"},   64'(tos),   64'd0);
        chk({tag, "_rst_nos"},   64'(nos),   64'd0);
        chk({tag, "_rst_depth"}, 64'(depth), 64'd0);
        chk({tag, "_rst_full"},  64'(full),  64'd0);
        chk({tag, "_rst_empty"}, 64'(empty), 64'd1);
        chk({tag, "_rst_ovf"},   64'(ovf),   64'd0);
        chk({tag, "_rst_unf"},   64'(unf),   64'd0);
        chk({tag, "_rst_ill"},   64'(ill),   64'd0);
        @(negedge clk);
        rst       = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = OP_PUSH;
        din       = 32'd99;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        $display("reset %s released, push in release cycle -> depth=%0d tos=%0d", tag, depth, tos);
        chk({tag, "_release_depth"}, 64'(depth), 64'd0);
        chk({tag, "_release_tos"},   64'(tos),   64'd0);
    endtask

    initial begin
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        din       = '0;
        clr_err   = 1'b0;
        repeat (2) @(posedge clk);
        do_reset("init");

        // Push three, pop two
        cmd(OP_PUSH, 32'd1, 1'b0);
        cmd(OP_PUSH, 32'd2, 1'b0);
        cmd(OP_PUSH, 32'd3, 1'b0);
        chk("p3_tos",   64'(tos),   64'd3);
        chk("p3_nos",   64'(nos),   64'd2);
        chk("p3_depth", 64'(depth), 64'd3);
        chk("p3_empty", 64'(empty), 64'd0);
        idle(1'b0);
        chk("idle_hold_depth", 64'(depth), 64'd3);
        chk("idle_hold_tos",   64'(tos),   64'd3);
        cmd(OP_DROP, '0, 1'b0);
        cmd(OP_DROP, '0, 1'b0);
        chk("d2_tos",   64'(tos),   64'd1);
        chk("d2_nos",   64'(nos),   64'd0);
        chk("d2_depth", 64'(depth), 64'd1);
        cmd(OP_DROP, '0, 1'b0);
        chk("d3_tos",   64'(tos),   64'd0);
        chk("d3_empty", 64'(empty), 64'd1);

        // Fill to the top, then one more push
        for (int i = 1; i <= 6; i++) begin
            cmd(OP_PUSH, 32'(i), 1'b0);
        end
        chk("fill_full",  64'(full),  64'd1);
        chk("fill_depth", 64'(depth), 64'd6);
        chk("fill_nos",   64'(nos),   64'd5);
        cmd(OP_PUSH, 32'd7, 1'b0);
        chk("over_ovf",   64'(ovf),   GUARD ? 64'd1 : 64'd0);
        chk("over_tos",   64'(tos),   GUARD ? 64'd6 : 64'd7);
        chk("over_depth", 64'(depth), GUARD ? 64'd6 : 64'd7);
        chk("over_full",  64'(full),  GUARD ? 64'd1 : 64'd0);
        idle(1'b1);
        chk("clr_ovf", 64'(ovf), 64'd0);
        cmd(OP_DROP, '0, 1'b0);
        chk("full_drop_tos", 64'(tos), GUARD ? 64'd5 : 64'd6);
        chk("full_drop_nos", 64'(nos), GUARD ? 64'd4 : 64'd5);
        do_reset("mid");

        // ROT / SWAP / DROP
        cmd(OP_PUSH, 32'd10, 1'b0);
        cmd(OP_PUSH, 32'd20, 1'b0);
        cmd(OP_PUSH, 32'd30, 1'b0);
        cmd(OP_ROT, '0, 1'b0);
        chk("rot_tos",   64'(tos),   64'd10);
        chk("rot_nos",   64'(nos),   64'd30);
        chk("rot_depth", 64'(depth), 64'd3);
        cmd(OP_SWAP, '0, 1'b0);
        chk("swap_tos", 64'(tos), 64'd30);
        chk("swap_nos", 64'(nos), 64'd10);
        cmd(OP_DROP, '0, 1'b0);
        chk("rot_drop_tos", 64'(tos), 64'd10);
        chk("rot_drop_nos", 64'(nos), 64'd20);
        cmd(OP_PUSH, 32'd40, 1'b0);
        cmd(OP_ROT, '0, 1'b0);
        cmd(OP_ROT, '0, 1'b0);
        chk("rot2_tos", 64'(tos), 64'd10);
        chk("rot2_nos", 64'(nos), 64'd20);
        cmd(OP_OVER, '0, 1'b0);
        chk("over_op_tos",   64'(tos),   64'd20);
        chk("over_op_nos",   64'(nos),   64'd10);
        chk("over_op_depth", 64'(depth), 64'd4);
        do_reset("t4");

        // Underflow and set-over-clear priority
        cmd(OP_PUSH, 32'd5, 1'b0);
        cmd(OP_SWAP, '0, 1'b1);
        chk("swap1_unf",   64'(unf),   GUARD ? 64'd1 : 64'd0);
        chk("swap1_tos",   64'(tos),   GUARD ? 64'd5 : 64'd0);
        chk("swap1_depth", 64'(depth), 64'd1);
        idle(1'b1);
        chk("clr_unf", 64'(unf), 64'd0);
        cmd(OP_DROP, '0, 1'b0);
        chk("drop1_depth", 64'(depth), 64'd0);
        cmd(OP_DROP, '0, 1'b0);
        chk("drop0_unf",   64'(unf),   GUARD ? 64'd1 : 64'd0);
        chk("drop0_depth", 64'(depth), GUARD ? 64'd0 : 64'd7);
        do_reset("t5");

        // BIN, REPL, DUP and an illegal opcode
        cmd(OP_PUSH, 32'd5, 1'b0);
        cmd(OP_PUSH, 32'd7, 1'b0);
        cmd(OP_BIN, 32'd12, 1'b0);
        chk("bin_tos",   64'(tos),   64'd12);
        chk("bin_depth", 64'(depth), 64'd1);
        chk("bin_nos",   64'(nos),   64'd0);
        cmd(4'd15, 32'd55, 1'b0);
        chk("ill_flag",  64'(ill),   64'd1);
        chk("ill_tos",   64'(tos),   64'd12);
        chk("ill_depth", 64'(depth), 64'd1);
        cmd(OP_REPL, 32'd44, 1'b1);
        chk("repl_tos", 64'(tos), 64'd44);
        chk("repl_ill", 64'(ill), 64'd0);
        cmd(OP_DUP, '0, 1'b0);
        chk("dup_tos",   64'(tos),   64'd44);
        chk("dup_nos",   64'(nos),   64'd44);
        chk("dup_depth", 64'(depth), 64'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stack_unit.md
STACK_UNIT -- requirements
Module: stack_unit

Interface
REQ-001 SHALL have parameter W, default 32: data word width (16..64).
REQ-002 SHALL have parameter DEPTH, default 256: RAM-spill entries below NOS; power of 2, at least 4.
REQ-003 SHALL derive DW = clog2(DEPTH+3) for the depth count.
REQ-004 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port cmd_valid, input, 1: a command is presented this cycle.
REQ-007 SHALL have port cmd_op, input, 4: opcode (REQ-013).
REQ-008 SHALL have port din, input, W: operand for PUSH, BIN and REPL.
REQ-009 SHALL have port clr_err, input, 1: clears the sticky error flags.
REQ-010 SHALL have ports tos and nos, output, W each: registered top and next-on-stack.
REQ-011 SHALL have port depth, output, DW: valid entries, counting TOS, NOS and RAM.
REQ-012 SHALL have ports full, empty, ovf, unf and ill, output, 1 each.

Function
REQ-013 SHALL decode opcodes as follows; any other code is treated as NOP and sets ill:
- 0 NOP; 1 PUSH; 2 DROP; 3 DUP; 4 SWAP; 5 OVER; 6 ROT; 7 BIN (pop two, push din); 8 REPL (tos<=din).
REQ-014 SHALL accept one command every cycle with no stall; tos, nos and depth reflect the command on the next edge.
REQ-015 SHALL hold state unchanged when cmd_valid=0.
REQ-016 SHALL spill on PUSH/DUP/OVER: ram[sp]<=nos, sp++, nos<=old tos, tos<=new value.
REQ-017 SHALL fill on DROP/BIN: nos<=ram[sp-1], sp--.
REQ-018 SHALL implement ROT ( a b c -> b c a ): tos<=ram[sp-1], ram[sp-1]<=nos, nos<=old tos, sp unchanged.
REQ-019 SHALL present ram[next_sp-1] at the start of each cycle via read-ahead addressing, so back-to-back push/pop/ROT run at full rate.
REQ-020 SHALL give minimum depths: DROP/DUP/REPL 1; SWAP/OVER/BIN 2; ROT 3.
REQ-021 SHALL treat PUSH/DUP/OVER at depth = DEPTH+2 as overflow.
REQ-022 SHALL assert full when depth = DEPTH+2 and empty when depth = 0, combinationally from registered depth.
REQ-023 SHALL give ovf, unf and ill sticky-set priority over clr_err when both occur in the same cycle.
REQ-024 SHALL zero tos when depth goes to 0, and zero nos when depth is at most 1.

Reset
REQ-025 SHALL, while rst=0, force tos=0, nos=0, sp=0, depth=0, ovf=unf=ill=0, full=0, empty=1.
REQ-026 SHALL discard a command presented in the cycle rst deasserts and leave RAM contents undefined.

Configuration
REQ-027 SHALL, with STACK_UNIT_GUARD_EN defined, suppress overflowing or underflowing commands (no state change) and set ovf/unf.
REQ-028 SHALL, without STACK_UNIT_GUARD_EN, execute every command, wrap sp modulo DEPTH and depth modulo 2^DW, tie ovf/unf to 0, and keep ill functional.

Structure
REQ-029 SHALL place opcode localparams and the minimum-depth table in shared package stack_unit_pkg, used by stack_unit and by client CPUs.
REQ-030 SHALL place storage in sub-module stack_unit_ram: DEPTH x W, sync write, sync read, write-first bypass when the read address equals the write address.

Verification (W=32, DEPTH=4, guard on unless stated)
REQ-031 SHALL cover: PUSH 1,2,3 on consecutive cycles -> tos=3, nos=2, depth=3; then DROP,DROP -> tos=1, nos=0, depth=1.
REQ-032 SHALL cover: PUSH 1..6 -> full=1; PUSH 7 -> ovf=1, tos=6, depth=6; clr_err -> ovf=0.
REQ-033 SHALL cover: stack 10,20,30 (tos=30), ROT -> tos=10, nos=30, next DROP exposes 20; SWAP -> tos=30, nos=10.
REQ-034 SHALL cover: empty stack, DROP -> unf=1, depth=0; simultaneous clr_err and SWAP at depth 1 -> unf stays 1.
REQ-035 SHALL cover: depth 2 (5,7), BIN din=12 -> tos=12, depth=1, nos=0; opcode 15 -> ill=1, state unchanged.
REQ-036 SHALL cover: guard off, 7 PUSHes -> no ovf, depth=7; async rst pulse mid-stream -> all outputs at reset values.
